// File: rtl/pe_array_ctrl.sv
// Sequencer for the pe_wrapper systolic array: latches weights, streams N vectors, flushes D cycles, tracks row-valid skew.
// Optional PE_CTRL_ZERO_FILL_EN: stream bubbles feed zero vectors instead of freezing the array.
module pe_array_ctrl #(
    parameter int KERNEL_SIZE   = 3,
    parameter int DATA_WIDTH    = 8,
    parameter int WEIGHT_WIDTH  = 8,
    parameter int VERTICAL_SKEW = 2,
    parameter int ADD_DELAY     = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic [CNT_WIDTH-1:0]                          cfg_num_vectors,
    input  logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] cfg_weights,
    input  logic                                          in_valid,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0]             in_data,
    output logic                                          in_ready,
    output logic                                          pe_en,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0]             pe_dataIn,
    output logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] pe_weightsIn,
    input  logic                                          pe_done,
    output logic [KERNEL_SIZE-1:0]                        out_row_valid,
    output logic [CNT_WIDTH-1:0]                          out_vec_cnt,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          sync_err
);

    localparam int FLUSH_LEN = VERTICAL_SKEW*(KERNEL_SIZE-1) + ADD_DELAY;
    localparam int FCW       = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                                          r_state;
    state_t                                          w_state_nxt;
    logic [CNT_WIDTH-1:0]                            r_num;
    logic [CNT_WIDTH-1:0]                            r_acc_cnt;
    logic [CNT_WIDTH-1:0]                            r_vec_cnt;
    logic [FCW-1:0]                                  r_flush_cnt;
    logic [FLUSH_LEN-1:0]                            r_tok;
    logic [WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] r_weights;
    logic                                            r_sync_err;
    logic                                            w_start_job;
    logic                                            w_accept;
    logic                                            w_en;
    logic                                            w_tok_in;

    assign w_start_job  = (r_state == S_IDLE) && start;
    assign pe_en        = w_en;
    assign pe_weightsIn = r_weights;
    assign out_vec_cnt  = r_vec_cnt;
    assign sync_err     = r_sync_err;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_accept    = 1'b0;
        w_en        = 1'b0;
        w_tok_in    = 1'b0;
        pe_dataIn   = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (cfg_num_vectors != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                busy        = 1'b1;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) begin
                    w_en      = 1'b1;
                    w_tok_in  = 1'b1;
                    pe_dataIn = in_data;
                    if (r_acc_cnt == r_num - CNT_WIDTH'(1)) begin
                        w_state_nxt = S_FLUSH;
                    end
                end else begin
`ifdef PE_CTRL_ZERO_FILL_EN
                    w_en = 1'b1;
`else
                    w_en = 1'b0;
`endif
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                w_en = 1'b1;
                if (r_flush_cnt == FCW'(FLUSH_LEN-1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Row r sees a vector VERTICAL_SKEW*r+ADD_DELAY enabled cycles after it was fed.
    always_comb begin
        out_row_valid = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            out_row_valid[r] = r_tok[VERTICAL_SKEW*r + ADD_DELAY - 1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num       <= '0;
            r_acc_cnt   <= '0;
            r_vec_cnt   <= '0;
            r_flush_cnt <= '0;
            r_tok       <= '0;
            r_weights   <= '0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_job) begin
                r_acc_cnt  <= '0;
                r_vec_cnt  <= '0;
                r_sync_err <= 1'b0;
                if (cfg_num_vectors != '0) begin
                    r_num     <= cfg_num_vectors;
                    r_weights <= cfg_weights;
                end
            end else begin
                if (w_accept) begin
                    r_acc_cnt <= r_acc_cnt + CNT_WIDTH'(1);
                end
                if (w_en && out_row_valid[KERNEL_SIZE-1]) begin
                    r_vec_cnt <= r_vec_cnt + CNT_WIDTH'(1);
                end
                if (w_en && out_row_valid[0] && !pe_done) begin
                    r_sync_err <= 1'b1;
                end
            end
            if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + FCW'(1);
            end else begin
                r_flush_cnt <= '0;
            end
            if (w_en) begin
                r_tok[0] <= w_tok_in;
                for (int i = 1; i < FLUSH_LEN; i++) begin
                    r_tok[i] <= r_tok[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Scoreboard bench for pe_array_ctrl: driver queues expected feeds/jobs, monitor checks against an enabled-cycle model.
module tb_pe_array_ctrl;
    localparam int K   = 3;
    localparam int DW  = 8;
    localparam int WW  = 8;
    localparam int VS  = 2;
    localparam int AD  = 1;
    localparam int CW  = 16;
    localparam int D   = VS*(K-1) + AD;
    localparam int VW  = DW*K;
    localparam int WTW = WW*K*K;

    typedef struct {
        int             n;
        int             mode;
        int             start_cyc;
        logic [WTW-1:0] w;
    } job_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic [CW-1:0]  cfg_num_vectors;
    logic [WTW-1:0] cfg_weights;
    logic           in_valid;
    logic [VW-1:0]  in_data;
    logic           in_ready;
    logic           pe_en;
    logic [VW-1:0]  pe_dataIn;
    logic [WTW-1:0] pe_weightsIn;
    logic           pe_done;
    logic [K-1:0]   out_row_valid;
    logic [CW-1:0]  out_vec_cnt;
    logic           busy;
    logic           done;
    logic           sync_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit sd_req   = 0;
    logic [VW-1:0] exp_data_q[$];
    job_t          job_q[$];

    pe_array_ctrl #(
        .KERNEL_SIZE(K), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
        .VERTICAL_SKEW(VS), .ADD_DELAY(AD), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_num_vectors(cfg_num_vectors), .cfg_weights(cfg_weights),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .pe_en(pe_en), .pe_dataIn(pe_dataIn), .pe_weightsIn(pe_weightsIn),
        .pe_done(pe_done), .out_row_valid(out_row_valid), .out_vec_cnt(out_vec_cnt),
        .busy(busy), .done(done), .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Array-side responder: pe_done normally high, dropped once on request when row 0 shows valid.
    initial begin
        pe_done = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pe_done = 1'b1;
            if (sd_req && out_row_valid[0]) begin
                pe_done = 1'b0;
                sd_req  = 1'b0;
            end
        end
    end

    // Monitor: expected row-valid computed from which enabled cycles carried a real vector.
    initial begin
        bit           fed[$];
        int           e, en_cnt, rdy_cnt, acc_cnt, k;
        logic [K-1:0] exp_orv;
        logic         exp_serr;
        bit           acc;
        job_t         j;
        e = 0; en_cnt = 0; rdy_cnt = 0; acc_cnt = 0; exp_serr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fed.delete(); e = 0; en_cnt = 0; rdy_cnt = 0; acc_cnt = 0;
                exp_serr = 1'b0;
            end else begin
                chk("sync_err", sync_err, exp_serr);
                if (!busy && start) begin
                    fed.delete(); e = 0; en_cnt = 0; rdy_cnt = 0; acc_cnt = 0;
                    exp_serr = 1'b0;
                end
                acc = in_valid && in_ready;
                if (pe_en) begin
                    for (int r = 0; r < K; r++) begin
                        k = e - (VS*r + AD);
                        exp_orv[r] = (k >= 0) ? fed[k] : 1'b0;
                    end
                    chk("row_valid", out_row_valid, exp_orv);
                    if (exp_orv[0] && !pe_done) exp_serr = 1'b1;
                    fed.push_back(acc);
                    e++;
                    en_cnt++;
                    if (!acc) chk("bubble_data", pe_dataIn, '0);
                end
                if (in_ready) rdy_cnt++;
                if (acc) begin
                    acc_cnt++;
                    chk("feed_en", pe_en, 1'b1);
                    if (exp_data_q.size() == 0) begin
                        chk("extra_accept", acc_cnt, 0);
                    end else begin
                        chk("feed_data", pe_dataIn, exp_data_q.pop_front());
                    end
                end
                if (done) begin
                    if (job_q.size() == 0) begin
                        chk("unexpected_done", done, 1'b0);
                    end else begin
                        j = job_q.pop_front();
                        chk("vec_cnt", out_vec_cnt, j.n);
                        chk("accepts", acc_cnt, j.n);
                        if (j.n != 0) chk("weights", pe_weightsIn, j.w);
                        if (j.n == 0) chk("ready_cycles", rdy_cnt, 0);
`ifdef PE_CTRL_ZERO_FILL_EN
                        chk("en_cycles", en_cnt, (j.n == 0) ? 0 : rdy_cnt + D);
`else
                        chk("en_cycles", en_cnt, (j.n == 0) ? 0 : j.n + D);
`endif
                        if (j.mode == 0) chk("done_latency", cyc - j.start_cyc, (j.n == 0) ? 1 : j.n + D + 2);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_pe_en"}, pe_en, 1'b0);
        chk({tag, "_row_valid"}, out_row_valid, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_sync_err"}, sync_err, 1'b0);
        chk({tag, "_dataIn"}, pe_dataIn, '0);
        chk({tag, "_weightsIn"}, pe_weightsIn, '0);
        chk({tag, "_vec_cnt"}, out_vec_cnt, '0);
    endtask

    function automatic logic [WTW-1:0] rand_w();
        logic [WTW-1:0] w;
        for (int i = 0; i < K*K; i++) w[i*WW +: WW] = WW'($urandom);
        return w;
    endfunction

    // mode 0: valid held; 1: one bubble after each accept; 2: random bubbles.
    task automatic run_job(input int n, input int mode, input int abort_after,
                           input bit mid_start, input bit force_sd, input logic [WTW-1:0] w);
        job_t          j;
        bit            acc;
        int            waited;
        logic [VW-1:0] vec;
        j.n = n; j.mode = mode; j.start_cyc = cyc; j.w = w;
        job_q.push_back(j);
        cfg_num_vectors = CW'(n);
        cfg_weights     = w;
        start           = 1'b1;
        if (force_sd) sd_req = 1'b1;
        step();
        start           = 1'b0;
        cfg_weights     = rand_w();
        cfg_num_vectors = CW'($urandom_range(20, 1));
        if (n != 0) chk("sync_err_cleared", sync_err, 1'b0);
        for (int i = 0; i < n; i++) begin
            vec = VW'($urandom);
            in_data  = vec;
            in_valid = 1'b1;
            exp_data_q.push_back(vec);
            acc = 1'b0;
            waited = 0;
            while (!acc && waited < 50) begin
                if (mid_start && i == 2 && waited == 0) begin
                    start = 1'b1;
                    cfg_num_vectors = CW'(9);
                end
                @(negedge clk);
                acc = in_ready;
                step();
                start = 1'b0;
                waited++;
            end
            if (!acc) begin
                chk("accept_timeout", acc, 1'b1);
                in_valid = 1'b0;
                return;
            end
            if (abort_after != 0 && i + 1 == abort_after) begin
                rst = 1'b1;
                #1;
                check_zero("mid_reset");
                exp_data_q.delete();
                job_q.delete();
                in_valid = 1'b0;
                sd_req   = 1'b0;
                step();
                rst = 1'b0;
                return;
            end
            if (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)) begin
                in_valid = 1'b0;
                repeat ((mode == 1) ? 1 : $urandom_range(3, 1)) step();
            end
        end
        in_valid = 1'b0;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = done;
            step();
            waited++;
        end
        chk("done_seen", acc, 1'b1);
        step();
    endtask

    initial begin
        logic [WTW-1:0] w_rows;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        cfg_num_vectors = '0; cfg_weights = '0;
        #1 rst = 1'b1;
        #1 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();

        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w_rows[(r*K + c)*WW +: WW] = WW'(r + 1);
        run_job(5, 0, 0, 1'b0, 1'b0, w_rows);
        run_job(5, 1, 0, 1'b0, 1'b0, rand_w());
        run_job(0, 0, 0, 1'b0, 1'b0, rand_w());
        run_job(6, 0, 2, 1'b0, 1'b0, rand_w());
        check_zero("after_abort");
        run_job(3, 0, 0, 1'b0, 1'b0, rand_w());
        run_job(5, 0, 0, 1'b1, 1'b1, rand_w());
        chk("sync_err_hold", sync_err, 1'b1);
        step();
        chk("sync_err_hold_idle", sync_err, 1'b1);
        for (int t = 0; t < 8; t++) begin
            run_job($urandom_range(12, 1), 2, 0, 1'b0, 1'b0, rand_w());
        end
        run_job(1, 0, 0, 1'b0, 1'b0, rand_w());
        chk("jobs_drained", job_q.size(), 0);
        chk("feeds_drained", exp_data_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
Sequencer for the systolic pe_wrapper convolution array.
- Latches a kernel weight set and streams a programmed number of input vectors from a valid/ready source into the array.
- Drives the array enable and flushes the pipeline after the last vector.
- Produces per-row result-valid flags that follow the array's vertical wavefront skew.
- Sits between the line-buffer/DMA front end and pe_wrapper; a host issues start and observes done.

Parameters:
KERNEL_SIZE, 3, array rows/cols; vector has KERNEL_SIZE pixels
DATA_WIDTH, 8, pixel width
WEIGHT_WIDTH, 8, weight width
VERTICAL_SKEW, 2, enabled cycles between adjacent row outputs
ADD_DELAY, 1, enabled cycles from feed to row-0 result
CNT_WIDTH, 16, vector counter width

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
start  in  1  begin a job; sampled only in IDLE
cfg_num_vectors  in  CNT_WIDTH  vectors in job, N
cfg_weights  in  WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE  kernel, latched at start
in_valid  in  1  source vector valid
in_data  in  DATA_WIDTH*KERNEL_SIZE  source vector
in_ready  out  1  controller accepts vector
pe_en  out  1  to pe_wrapper en
pe_dataIn  out  DATA_WIDTH*KERNEL_SIZE  to pe_wrapper dataIn
pe_weightsIn  out  WEIGHT_WIDTH*KERNEL_SIZE*KERNEL_SIZE  to pe_wrapper weightsIn, latched copy
pe_done  in  1  from pe_wrapper dataOut_done
out_row_valid  out  KERNEL_SIZE  bit r: row r result on dataOut belongs to a real vector
out_vec_cnt  out  CNT_WIDTH  completed vectors in current job
busy  out  1  job in progress
done  out  1  one-cycle job-complete pulse
sync_err  out  1  sticky: pe_done low while out_row_valid[0]=1 and pe_en=1

Behaviour:
- Reset (asynchronous, any state including mid-job) forces:
  - state IDLE; all counters and the token shift register to 0.
  - in_ready, pe_en, out_row_valid, busy, done, sync_err = 0.
  - pe_dataIn, pe_weightsIn, out_vec_cnt = 0.
- Define D = VERTICAL_SKEW*(KERNEL_SIZE-1)+ADD_DELAY (default 5).
- States:
  - IDLE:
    - start with N!=0: latch cfg_weights and N, clear out_vec_cnt and sync_err, go to LOAD.
    - start with N=0: go to DONE.
  - LOAD: one cycle. busy=1, pe_en=0, pe_weightsIn valid. Go to STREAM.
  - STREAM:
    - in_ready=1 combinationally.
    - On accept (in_valid&in_ready): pe_dataIn=in_data, pe_en=1, push token 1.
    - No accept: pe_en=0, pipeline and tokens frozen.
    - After the Nth accept go to FLUSH; in_ready drops in the cycle after the Nth accept.
  - FLUSH: exactly D cycles, pe_en=1, pe_dataIn=0, token 0 pushed. Then DONE.
  - DONE: done=1 for one cycle, busy=1. Next state IDLE (busy=0).
- Token shift register sr[0..D-1]:
  - Shifts only when pe_en=1.
  - out_row_valid[r] = sr[VERTICAL_SKEW*r+ADD_DELAY-1].
  - out_row_valid is meaningful for capture only on pe_en=1 cycles.
- out_vec_cnt increments when pe_en && out_row_valid[KERNEL_SIZE-1]; it equals N at DONE.
- start while busy is ignored. cfg_* changes after start have no effect.
- sync_err sets on pe_en && out_row_valid[0] && !pe_done and holds until the next accepted start.
- Counter widths: N up to 2^CNT_WIDTH-1; no wrap within a job.

Optional Feature:
PE_CTRL_ZERO_FILL_EN
- Defined: in STREAM, a cycle with no accept still asserts pe_en=1, drives pe_dataIn=0 and pushes token 0, so the array never stalls. Bubbles appear as 0 bits in out_row_valid.
- Undefined: bubbles freeze the array (pe_en=0), as described above.

Test Plan:
1. KERNEL_SIZE=3, row-r weights = r+1, N=5, vectors [i,i+1,i+2] with in_valid held high, start at cycle 0:
   - LOAD at cycle 1; accepts at cycles 2-6.
   - out_row_valid[0] high at cycles 3-7, [1] at 5-9, [2] at 7-11.
   - dataOut row sums for vector i: row0 = 3i+3, row1 = 2*(3i+3), row2 = 3*(3i+3).
   - done pulses at cycle 12; out_vec_cnt=5.
2. Same job with in_valid toggling every other cycle:
   - pe_en high for exactly 5 STREAM cycles plus 5 FLUSH cycles.
   - Identical row-valid sequence over enabled cycles; out_vec_cnt=5.
3. start with N=0: done pulses the cycle after start; pe_en and in_ready never assert.
4. rst asserted mid-STREAM after 2 accepts:
   - All outputs 0 immediately, state IDLE.
   - A new job with N=3 completes with out_vec_cnt=3 and no stale out_row_valid bits.
5. start pulsed during STREAM is ignored (job N=5 unaffected).
   - Force pe_done=0 on the first row-0-valid cycle: sync_err rises and holds until the next start.
6. With PE_CTRL_ZERO_FILL_EN, rerun test 2:
   - pe_en high every STREAM cycle.
   - out_row_valid[0] pattern 1,0,1,0,1,0,1,0,1.
   - out_vec_cnt=5.
